// File: rtl/lock_rst_seq_if.sv
// Lock/reset sequencer signal bundle: lock and restart in, staged resets and status out.
interface lock_rst_seq_if #(
  parameter int NUM_STAGES = 3
);
  logic                  i_locked;
  logic                  i_restart;
  logic [NUM_STAGES-1:0] o_rst;
  logic                  o_ready;
  logic [7:0]            o_loss_count;

  modport master (
    output i_locked,
    output i_restart,
    input  o_rst,
    input  o_ready,
    input  o_loss_count
  );

  modport slave (
    input  i_locked,
    input  i_restart,
    output o_rst,
    output o_ready,
    output o_loss_count
  );
endinterface

// File: rtl/lock_rst_seq.sv
// Qualifies an asynchronous PLL lock, then releases NUM_STAGES resets in index order
// spaced STAGE_GAP cycles apart; lock loss or restart re-asserts all resets at once.
module lock_rst_seq #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int NUM_STAGES    = 3,
  parameter int STAGE_GAP     = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  lock_rst_seq_if.slave bus
);

  localparam int QW = $clog2(STABLE_CYCLES);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam logic [QW-1:0]         QUAL_LAST = QW'(STABLE_CYCLES - 1);
  localparam logic [GW-1:0]         GAP_LAST  = GW'(STAGE_GAP - 1);
  localparam logic [NUM_STAGES-1:0] ALL_RST   = '1;
  localparam logic [NUM_STAGES-1:0] FIRST_RST = ALL_RST << 1;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_STABLE  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  state_t                  r_state;
  logic [SYNC_STAGES-1:0]  r_sync;
  logic [QW-1:0]           r_qual;
  logic [GW-1:0]           r_gap;
  logic [NUM_STAGES-1:0]   r_rst;
  logic                    r_ready;
  logic [7:0]              r_loss_count;

  logic                    w_locked_s;
  logic [NUM_STAGES-1:0]   w_rst_shift;

  assign w_locked_s  = r_sync[SYNC_STAGES-1];
  // Resets only ever fall from bit 0 upward, so the next release pattern is a left shift.
  assign w_rst_shift = r_rst << 1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_WAIT;
      r_sync       <= '0;
      r_qual       <= '0;
      r_gap        <= '0;
      r_rst        <= ALL_RST;
      r_ready      <= 1'b0;
      r_loss_count <= 8'd0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_locked};
      case (r_state)
        ST_WAIT: begin
          r_rst   <= ALL_RST;
          r_ready <= 1'b0;
          if (w_locked_s) begin
            r_state <= ST_STABLE;
            r_qual  <= '0;
          end
        end
        ST_STABLE: begin
          if (!w_locked_s || bus.i_restart) begin
            r_state <= ST_WAIT;
          end else if (r_qual == QUAL_LAST) begin
            r_rst <= FIRST_RST;
            r_gap <= '0;
            if (FIRST_RST == '0) begin
              r_ready <= 1'b1;
              r_state <= ST_RUN;
            end else begin
              r_state <= ST_RELEASE;
            end
          end else begin
            r_qual <= r_qual + 1'b1;
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (!w_locked_s) begin
            r_rst   <= ALL_RST;
            r_ready <= 1'b0;
            r_state <= ST_WAIT;
            if (r_loss_count != 8'hFF) begin
              r_loss_count <= r_loss_count + 8'd1;
            end
          end else if (bus.i_restart) begin
            r_rst   <= ALL_RST;
            r_ready <= 1'b0;
            r_state <= ST_WAIT;
          end else if (r_state == ST_RELEASE) begin
            if (r_gap == GAP_LAST) begin
              r_gap <= '0;
              r_rst <= w_rst_shift;
              if (w_rst_shift == '0) begin
                r_ready <= 1'b1;
                r_state <= ST_RUN;
              end
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
        end
        default: r_state <= ST_WAIT;
      endcase
    end
  end

  assign bus.o_rst        = r_rst;
  assign bus.o_ready      = r_ready;
  assign bus.o_loss_count = r_loss_count;

endmodule

// File: tb/tb_lock_rst_seq.sv
// Directed bench: stimulus queues expected output changes with their edge numbers,
// a negedge monitor pops and compares them whenever outputs change or a probe is due.
module tb_lock_rst_seq;

  logic i_clk = 1'b0;
  logic i_rst;
  int   cyc = 0;

  lock_rst_seq_if #(.NUM_STAGES(3)) bus ();

  lock_rst_seq #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(16),
    .NUM_STAGES   (3),
    .STAGE_GAP    (4)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] rst;
    logic       rdy;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         mon_on = 0;
  bit         final_chk = 0;
  bit         final_done = 0;
  logic [2:0] prev_rst;
  logic       prev_rdy;
  logic [7:0] prev_cnt;
  logic       chg;
  logic [7:0] exp_cnt;

  // Monitor: an output change or a due probe consumes exactly one scoreboard entry.
  always @(negedge i_clk) begin
    if (mon_on) begin
      chg = (bus.o_rst !== prev_rst) || (bus.o_ready !== prev_rdy) ||
            (bus.o_loss_count !== prev_cnt);
      if (chg || (sb.size() > 0 && sb[0].cyc == cyc)) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change edge=%0d got rst=%b rdy=%b cnt=%0d, required no change",
                   cyc, bus.o_rst, bus.o_ready, bus.o_loss_count);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || bus.o_rst !== e.rst || bus.o_ready !== e.rdy ||
              bus.o_loss_count !== e.cnt) begin
            n_bad++;
            $display("FAIL output_event got edge=%0d rst=%b rdy=%b cnt=%0d, required edge=%0d rst=%b rdy=%b cnt=%0d",
                     cyc, bus.o_rst, bus.o_ready, bus.o_loss_count, e.cyc, e.rst, e.rdy, e.cnt);
          end
        end
      end
      if (final_chk && !final_done) begin
        final_done = 1;
        n_cmp++;
        if (sb.size() != 0) begin
          n_bad++;
          $display("FAIL pending_expectations got %0d left, required 0 (next edge=%0d)",
                   sb.size(), sb[0].cyc);
        end
      end
    end
    prev_rst = bus.o_rst;
    prev_rdy = bus.o_ready;
    prev_cnt = bus.o_loss_count;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic expect_at(input int c, input logic [2:0] r, input logic rd, input logic [7:0] n);
    exp_t x;
    x.cyc = c;
    x.rst = r;
    x.rdy = rd;
    x.cnt = n;
    sb.push_back(x);
  endtask

  // Staged release: bit 0 at t0, then one bit per 4 edges, ready with the last.
  task automatic release_at(input int t0);
    expect_at(t0,     3'b110, 1'b0, exp_cnt);
    expect_at(t0 + 4, 3'b100, 1'b0, exp_cnt);
    expect_at(t0 + 8, 3'b000, 1'b1, exp_cnt);
  endtask

  // From WAIT with a cleared synchroniser: lock seen at E0, first release at E0+18.
  task automatic relock();
    int e0;
    bus.i_locked = 1'b1;
    e0 = cyc + 1;
    release_at(e0 + 18);
    wait_until(e0 + 27);
  endtask

  task automatic lose_lock();
    int f0;
    bus.i_locked = 1'b0;
    f0 = cyc + 1;
    exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
    expect_at(f0 + 2, 3'b111, 1'b0, exp_cnt);
    wait_until(f0 + 3);
  endtask

  initial begin
    int e0;
    int r;
    int r2;
    int f0;
    i_rst         = 1'b1;
    bus.i_locked  = 1'b0;
    bus.i_restart = 1'b0;
    exp_cnt       = 8'd0;
    repeat (3) tick();

    // Reset state probe
    expect_at(cyc + 1, 3'b111, 1'b0, 8'd0);
    mon_on = 1;
    tick();
    tick();

    // Clean first lock, reset released together with lock rising
    i_rst = 1'b0;
    relock();

    // Lock loss from RUN, a restart pulse in WAIT that must be ignored, then re-lock
    lose_lock();
    bus.i_restart = 1'b1;
    tick();
    bus.i_restart = 1'b0;
    tick();
    relock();

    // Restart in RUN; locked_s is already high, so qualification starts on the next edge
    bus.i_restart = 1'b1;
    r = cyc + 1;
    expect_at(r, 3'b111, 1'b0, exp_cnt);
    tick();
    bus.i_restart = 1'b0;
    release_at(r + 17);
    wait_until(r + 26);

    // Restart in RELEASE right after bit 0 has fallen
    bus.i_restart = 1'b1;
    r = cyc + 1;
    expect_at(r, 3'b111, 1'b0, exp_cnt);
    tick();
    bus.i_restart = 1'b0;
    expect_at(r + 17, 3'b110, 1'b0, exp_cnt);
    wait_until(r + 17);
    bus.i_restart = 1'b1;
    r2 = cyc + 1;
    expect_at(r2, 3'b111, 1'b0, exp_cnt);
    tick();
    bus.i_restart = 1'b0;
    release_at(r2 + 17);
    wait_until(r2 + 26);

    // One-cycle lock dropout during qualification: no count, qualification restarts
    lose_lock();
    bus.i_locked = 1'b1;
    e0 = cyc + 1;
    expect_at(e0 + 28, 3'b111, 1'b0, exp_cnt);
    release_at(e0 + 29);
    wait_until(e0 + 9);
    bus.i_locked = 1'b0;
    tick();
    bus.i_locked = 1'b1;
    wait_until(e0 + 38);

    // Bring the loss count to 5, then reset in RUN with coincident loss and restart
    for (int i = 0; i < 3; i++) begin
      lose_lock();
      relock();
    end
    bus.i_locked = 1'b0;
    f0 = cyc + 1;
    wait_until(f0 + 1);
    i_rst         = 1'b1;
    bus.i_restart = 1'b1;
    exp_cnt       = 8'd0;
    expect_at(cyc + 1, 3'b111, 1'b0, 8'd0);
    tick();
    tick();
    i_rst         = 1'b0;
    bus.i_restart = 1'b0;
    relock();

    // 300 losses from RUN: count saturates at 255
    for (int i = 0; i < 300; i++) begin
      lose_lock();
      relock();
    end
    expect_at(cyc + 2, 3'b000, 1'b1, 8'd255);
    repeat (4) tick();

    final_chk = 1;
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lock_rst_seq.md
LOCK_RST_SEQ -- requirements
Module: lock_rst_seq

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchroniser flops on i_locked (legal range 2..4).
REQ-002 Parameter STABLE_CYCLES, default 16, number of consecutive synchronised-lock cycles required before release (legal range 2..65535).
REQ-003 Parameter NUM_STAGES, default 3, number of reset outputs released in sequence (legal range 1..8).
REQ-004 Parameter STAGE_GAP, default 4, cycles between successive stage releases (legal range 1..255).
REQ-005 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-006 i_rst  input  1  reset, synchronous, active-high.
REQ-007 i_locked  input  1  PLL/MMCM lock, asynchronous to i_clk.
REQ-008 i_restart  input  1  single-cycle request to re-run the reset sequence.
REQ-009 o_rst  output  NUM_STAGES  per-stage reset, active-high, registered; bit 0 releases first.
REQ-010 o_ready  output  1  high only while all o_rst bits are low, registered.
REQ-011 o_loss_count  output  8  lock-loss event counter, saturating at 255.

Function
REQ-012 i_locked SHALL pass through SYNC_STAGES flops, with no logic between them, to form locked_s; the FSM SHALL use only locked_s.
REQ-013 The FSM SHALL have exactly four states: WAIT, STABLE, RELEASE, RUN.
REQ-014 WAIT: all o_rst bits = 1 and o_ready = 0; on an edge with locked_s=1, go to STABLE and clear the qualify counter.
REQ-015 STABLE: on each edge with locked_s=1, increment the qualify counter; on an edge with locked_s=0, return to WAIT with no o_loss_count change.
REQ-016 STABLE exit: on the edge where locked_s=1 and the counter equals STABLE_CYCLES-1, clear o_rst[0] and go to RELEASE.
REQ-017 RELEASE: clear o_rst[k] exactly STAGE_GAP edges after o_rst[k-1] is cleared.
REQ-018 On the edge that clears o_rst[NUM_STAGES-1], set o_ready=1 and go to RUN.
REQ-019 If NUM_STAGES=1, go directly from STABLE to RUN with o_ready=1 on the edge defined in REQ-016.
REQ-020 Release timing: let E0 be the first edge at which sync stage 1 samples i_locked=1 after WAIT is entered. Then o_rst[k] falls at edge E0+SYNC_STAGES+STABLE_CYCLES+k*STAGE_GAP, and o_ready rises with the last stage.
REQ-021 Lock loss: on an edge in RELEASE or RUN with locked_s=0, set all o_rst bits to 1 and o_ready to 0, increment o_loss_count (holding at 255), and go to WAIT.
REQ-022 Lock-loss reaction time SHALL be SYNC_STAGES edges after the first edge sampling i_locked=0.
REQ-023 i_restart: on an edge with i_restart=1 in STABLE, RELEASE or RUN, set all o_rst bits to 1 and o_ready to 0 and go to WAIT, with no count change.
REQ-024 i_restart in WAIT SHALL be ignored.
REQ-025 Priority: i_rst > lock loss > i_restart; lock loss and i_restart on the same edge SHALL count one loss.
REQ-026 o_rst bits SHALL only fall in index order and SHALL all rise on the same edge; no output glitches (all registered).
REQ-027 The qualify counter and the gap counter SHALL be wide enough for the maximum parameter values; there SHALL be no wrap before the terminal value.

Reset
REQ-028 On an edge with i_rst=1: state=WAIT, o_rst=all ones, o_ready=0, o_loss_count=0, all sync flops=0, all counters=0.
REQ-029 Reset applied mid-RELEASE or mid-RUN SHALL take effect on that edge, overriding all other inputs.
REQ-030 After i_rst deasserts, the sequence SHALL restart per REQ-014..REQ-020.

Verification (defaults: SYNC_STAGES=2, STABLE_CYCLES=16, NUM_STAGES=3, STAGE_GAP=4)
REQ-031 i_locked held high from E0 -> o_rst=3'b111 until E18; 3'b110 at E18; 3'b100 at E22; 3'b000 with o_ready=1 at E26.
REQ-032 i_locked high for 10 cycles, low for 1 cycle (visible on locked_s), then high -> o_rst stays 3'b111, o_loss_count=0, qualification restarts from 0.
REQ-033 In RUN, i_locked falls at sample edge F0 -> o_rst=3'b111 and o_ready=0 at F0+2, o_loss_count=1; re-lock then repeats the REQ-031 timing.
REQ-034 300 lock-loss events from RUN -> o_loss_count reads 255 and does not wrap.
REQ-035 i_restart pulse in RUN, and separately in RELEASE after o_rst=3'b110 -> o_rst=3'b111 on the next edge, count unchanged, full release timing repeats.
REQ-036 i_rst asserted in RUN with o_loss_count=5 -> o_rst=3'b111, o_ready=0, o_loss_count=0 on that edge; i_restart and lock loss coincident with i_rst are ignored.
